// File: rtl/serial_logic_sequencer_if.sv
// Handshake and data bundle between the sequencer and its driver / compute slice.
// Op_Count exists only when SEQ_OP_COUNT_EN is defined.
interface serial_logic_sequencer_if #(
    parameter int N = 8
);
    logic         LoadA;
    logic         LoadB;
    logic         Execute;
    logic [N-1:0] Din;
    logic [2:0]   F;
    logic [1:0]   R;
    logic [2:0]   F_Sel;
    logic         A_Bit;
    logic         B_Bit;
    logic         F_A_B;
    logic [N-1:0] Aval;
    logic [N-1:0] Bval;
    logic         Busy;
    logic         Done;
`ifdef SEQ_OP_COUNT_EN
    logic [7:0]   Op_Count;

    modport master (
        output LoadA, LoadB, Execute, Din, F, R, F_A_B,
        input  F_Sel, A_Bit, B_Bit, Aval, Bval, Busy, Done, Op_Count
    );
    modport slave (
        input  LoadA, LoadB, Execute, Din, F, R, F_A_B,
        output F_Sel, A_Bit, B_Bit, Aval, Bval, Busy, Done, Op_Count
    );
`else
    modport master (
        output LoadA, LoadB, Execute, Din, F, R, F_A_B,
        input  F_Sel, A_Bit, B_Bit, Aval, Bval, Busy, Done
    );
    modport slave (
        input  LoadA, LoadB, Execute, Din, F, R, F_A_B,
        output F_Sel, A_Bit, B_Bit, Aval, Bval, Busy, Done
    );
`endif
endinterface

// File: rtl/serial_logic_sequencer.sv
// Bit-serial operand sequencer: shifts A/B LSB-first through a 1-bit slice for N cycles.
// Optional macro SEQ_OP_COUNT_EN adds an 8-bit completed-operation counter.
module serial_logic_sequencer #(
    parameter int N = 8
) (
    input logic                      Clk,
    input logic                      Reset,
    serial_logic_sequencer_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t          r_state, w_state;
    logic [N-1:0]    r_a, w_a;
    logic [N-1:0]    r_b, w_b;
    logic [CW-1:0]   r_cnt, w_cnt;
    logic [2:0]      r_fsel, w_fsel;
    logic [1:0]      r_route, w_route;
    logic            r_done, w_done;
    logic            w_a_in, w_b_in;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_cnt   <= '0;
            r_fsel  <= '0;
            r_route <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_a     <= w_a;
            r_b     <= w_b;
            r_cnt   <= w_cnt;
            r_fsel  <= w_fsel;
            r_route <= w_route;
            r_done  <= w_done;
        end
    end

    // Route table selects what refills each register's MSB
    always_comb begin
        w_a_in = r_a[0];
        w_b_in = r_b[0];
        unique case (r_route)
            2'b01:   w_a_in = bus.F_A_B;
            2'b10:   w_b_in = bus.F_A_B;
            2'b11: begin
                w_a_in = r_b[0];
                w_b_in = r_a[0];
            end
            default: ;
        endcase
    end

    always_comb begin
        w_state = r_state;
        w_a     = r_a;
        w_b     = r_b;
        w_cnt   = r_cnt;
        w_fsel  = r_fsel;
        w_route = r_route;
        w_done  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.LoadA || bus.LoadB) begin
                    if (bus.LoadA) w_a = bus.Din;
                    if (bus.LoadB) w_b = bus.Din;
                end else if (bus.Execute) begin
                    w_fsel  = bus.F;
                    w_route = bus.R;
                    w_cnt   = '0;
                    w_state = S_SHIFT;
                end
            end
            S_SHIFT: begin
                w_a = {w_a_in, r_a[N-1:1]};
                w_b = {w_b_in, r_b[N-1:1]};
                if (r_cnt == CW'(N - 1)) begin
                    w_state = S_HOLD;
                    w_done  = 1'b1;
                end else begin
                    w_cnt = r_cnt + CW'(1);
                end
            end
            S_HOLD: begin
                if (!bus.Execute) w_state = S_IDLE;
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.F_Sel = r_fsel;
    assign bus.A_Bit = r_a[0];
    assign bus.B_Bit = r_b[0];
    assign bus.Aval  = r_a;
    assign bus.Bval  = r_b;
    assign bus.Busy  = (r_state == S_SHIFT);
    assign bus.Done  = r_done;

`ifdef SEQ_OP_COUNT_EN
    logic [7:0] r_op_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)       r_op_cnt <= 8'd0;
        else if (r_done) r_op_cnt <= r_op_cnt + 8'd1;
    end

    assign bus.Op_Count = r_op_cnt;
`endif

endmodule

// File: doc/serial_logic_sequencer.md
Name: serial_logic_sequencer

Overview:
Controller and register unit for the 1-bit logic compute slice in the bit-serial logic processor. It holds two N-bit operand registers, A and B, and loads them from switches. On Execute it shifts both registers LSB-first through the external compute slice for exactly N cycles. Each result bit is routed back into A and/or B according to the route select, so one operation processes whole words through the single-bit ALU.

Parameters:
N, 8, operand width in bits; legal range 2..32.

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
LoadA  input  1  load Din into A (honoured in IDLE only)
LoadB  input  1  load Din into B (honoured in IDLE only)
Execute  input  1  level request to start one N-bit operation
Din  input  N  parallel load data
F  input  3  function select; latched at operation start
R  input  2  route select; latched at operation start
F_Sel  output  3  latched function, driven to the compute slice
A_Bit  output  1  A[0], combinational, to the compute slice
B_Bit  output  1  B[0], combinational, to the compute slice
F_A_B  input  1  result bit returned from the compute slice in the same cycle
Aval  output  N  A register contents
Bval  output  N  B register contents
Busy  output  1  high in SHIFT
Done  output  1  one-cycle pulse on the cycle after the last shift

Behaviour:
- Reset (asynchronous): state=IDLE, A=0, B=0, count=0, F_Sel=000, route=00, Busy=0, Done=0.
- States:
  - IDLE: LoadA/LoadB capture Din on the clock edge. Both asserted together load both registers. If any load is asserted, Execute is ignored that cycle. Otherwise Execute=1 latches F->F_Sel and R->route, clears count, and moves to SHIFT.
  - SHIFT: on every edge both registers shift right by one. The new MSB of each comes from the route table below. count increments. On the edge where count==N-1, move to HOLD and assert Done for the following cycle. Busy=1 for exactly N cycles.
  - HOLD: wait for Execute=0, then move to IDLE. A held Execute therefore runs exactly one operation.
- Route table (route, A MSB-in, B MSB-in):
  - 00: A[0], B[0] (rotate; registers unchanged after N shifts).
  - 01: F_A_B, B[0].
  - 10: A[0], F_A_B.
  - 11: B[0], A[0] (swap after N shifts).
- Loads are ignored in SHIFT and HOLD. F and R changes during an operation have no effect.
- Compute path is combinational: A_Bit/B_Bit -> slice -> F_A_B, sampled the same edge. No pipeline latency inside the loop.
- Total latency: Execute sampled high in IDLE -> N SHIFT cycles -> Done high on cycle N+1 after the start edge.
- Reset asserted mid-SHIFT aborts immediately to the reset values; a partial result is never retained.
- count width is clog2(N); it never wraps within an operation.

Optional Feature:
SEQ_OP_COUNT_EN:
- Defined: adds output Op_Count[7:0]. Reset value 0. Increments on each Done pulse and wraps 255->0. An aborted operation does not count.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- N=8: load A=0x33, B=0x55; F=000, R=01, Execute pulse -> Busy high 8 cycles, Done pulse, Aval=0x11, Bval=0x55.
- A=0x33, B=0x55, F=010, R=10 -> Bval=0x66, Aval=0x33. Then R=00, any F -> both registers unchanged.
- A=0x33, B=0x55, R=11 -> Aval=0x55, Bval=0x33. Execute held high 20 cycles -> exactly one Done; IDLE reached only after Execute falls.
- During SHIFT, assert LoadA with Din=0xFF and change F/R -> ignored; result matches the latched F/R.
- Reset asserted after 3 SHIFT cycles -> Aval=Bval=0, Busy=0, Done never pulses. A fresh op afterwards completes normally.
- With SEQ_OP_COUNT_EN: 257 operations -> Op_Count=1; one aborted operation leaves the count unchanged.
